// File: rtl/mux_n_reg.sv
// mux_n_reg: registered NUM_IN-to-1 mux with valid/ready handshake; define MUX_N_REG_SKID_EN for a one-entry skid and registered in_ready
module mux_n_reg #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt
);
  localparam logic [SEL_W:0] NUM_W = NUM_IN[SEL_W:0];
  logic [WIDTH-1:0] w_data;
  logic             w_err;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic             r_valid;
  logic [15:0]      r_cnt;
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_IN; k++) w_data = (sel == k[SEL_W-1:0]) ? in_bus[k*WIDTH +: WIDTH] : w_data;
  end
  assign w_err      = {1'b0, sel} >= NUM_W;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_valid && out_ready;
  assign out_data   = r_data;
  assign out_err    = r_err;
  assign out_valid  = r_valid;
  assign xfer_cnt   = r_cnt;
  always_ff @(posedge clk)
    if (reset) r_cnt <= '0;
    else if (w_out_xfer) r_cnt <= r_cnt + 16'd1;
`ifdef MUX_N_REG_SKID_EN
  logic             r_skid_empty;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  assign in_ready = r_skid_empty;
  // a full skid blocks new inputs, so it only drains into the output stage
  always_ff @(posedge clk)
    if (reset) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_skid_empty <= 1'b1;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (!r_skid_empty) begin
      if (w_out_xfer) begin
        r_data       <= r_skid_data;
        r_err        <= r_skid_err;
        r_skid_empty <= 1'b1;
      end
    end else if (w_in_xfer && r_valid && !out_ready) begin
      r_skid_data  <= w_data;
      r_skid_err   <= w_err;
      r_skid_empty <= 1'b0;
    end else if (w_in_xfer) begin
      r_data  <= w_data;
      r_err   <= w_err;
      r_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
`else
  assign in_ready = !r_valid || out_ready;
  always_ff @(posedge clk)
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_in_xfer) begin
      r_data  <= w_data;
      r_err   <= w_err;
      r_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg: scoreboard bench with a queue-based reference model of the registered mux
module tb_mux_n_reg;
  localparam int W = 32;
  localparam int N = 6;
  localparam int SW = $clog2(N);
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N*W-1:0] in_bus;
  logic [W-1:0]  ch [N];
  logic [SW-1:0] sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   xfer_cnt;
  int            checks = 0;
  int            errors = 0;
  logic [W:0]    q [$];
  logic [W:0]    e;
  logic [15:0]   exp_cnt = '0;
  bit            rst_seen = 1'b0;

  mux_n_reg #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  always_comb for (int k = 0; k < N; k++) in_bus[k*W +: W] = ch[k];

  function automatic logic [W:0] model(input logic [SW-1:0] s);
    return (int'(s) < N) ? {1'b0, ch[s]} : {1'b1, {W{1'b0}}};
  endfunction

  task automatic chk(input string n, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_cnt = '0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("rst_data", {1'b0, out_data}, '0);
        chk("rst_err", {{W{1'b0}}, out_err}, '0);
        chk("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
        rst_seen = 1'b0;
      end
      chk("xfer_cnt", {{(W-15){1'b0}}, xfer_cnt}, {{(W-15){1'b0}}, exp_cnt});
      chk("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, q.size() != 0});
`ifdef MUX_N_REG_SKID_EN
      chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, q.size() < 2});
`else
      chk("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, q.size() == 0 || out_ready});
`endif
      if (out_valid && out_ready) begin
        exp_cnt++;
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_result", {out_err, out_data}, e);
        end
      end
      if (in_valid && in_ready) q.push_back(model(sel));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic r);
    sel = SW'(s);
    in_valid = v;
    out_ready = r;
  endtask

  task automatic rand_ch();
    for (int k = 0; k < N; k++) ch[k] = $urandom;
  endtask

  initial begin
    for (int k = 0; k < N; k++) ch[k] = 32'h1000_0000 + k;
    repeat (3) cyc();
    reset = 1'b0;
    drive(5, 1, 1); cyc();
    in_valid = 1'b0; cyc(); cyc();
    drive(7, 1, 1); cyc();
    drive(2, 1, 1); cyc();
    in_valid = 1'b0; cyc();
    for (int s = 0; s < 4; s++) begin
      drive(s, 1, 1); cyc();
    end
    in_valid = 1'b0; cyc(); cyc();
    drive(1, 1, 0); cyc();
    for (int i = 0; i < 3; i++) begin
      rand_ch();
      sel = SW'($urandom);
      cyc();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) cyc();
    drive(4, 1, 0); cyc(); cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; in_valid = 1'b0; cyc(); cyc();
    repeat (2000) begin
      rand_ch();
      sel = SW'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      cyc();
    end
    drive(3, 1, 1);
    repeat (65540) cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("drained", {{W{1'b0}}, q.size() == 0}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
